// File: rtl/tt_sweep_pkg.sv
// Shared constants and helpers for the truth-table sweep controller.
// Every file that needs the state codes or the settle counter width imports this package.
package tt_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // SETTLE_CYC is at most 255, so an 8-bit counter is wide enough.
  localparam int SETTLE_CNT_W = 8;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter for the settle interval.
// It reloads to SETTLE_CYC-1, counts down while enabled, and raises zero on the last settle cycle.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [SETTLE_CNT_W-1:0] cnt_reg;
  logic [SETTLE_CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = SETTLE_CNT_W'(SETTLE_CYC - 1);
    end else if (en && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 2**N_IN input vectors into a combinational netlist, captures its output as a
// truth table, and compares the result against a golden table latched when the sweep starts.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN       = 4,
  parameter  int SETTLE_CYC = 2,
  localparam int TT_W       = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            result_valid,
  output logic [TT_W-1:0] tt_out,
  output logic            match,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid
);

  state_t          state_reg, state_next;
  logic [N_IN-1:0] idx_reg, idx_next;
  logic [TT_W-1:0] exp_reg, exp_next;
  logic [TT_W-1:0] tt_reg, tt_next;
  logic            valid_reg, valid_next;
  logic [N_IN:0]   mcnt_reg, mcnt_next;
  logic [N_IN-1:0] ffi_reg, ffi_next;
  logic            ffv_reg, ffv_next;

  logic            in_idle, accept, kill, last_idx, bit_miss;
  logic            timer_load, timer_en, timer_zero;
  logic [TT_W-1:0] idx_sel;

  assign in_idle  = (state_reg == ST_IDLE);
  assign accept   = in_idle && start && !abort;
  assign kill     = !in_idle && abort;
  assign last_idx = (idx_reg == N_IN'(TT_W - 1));
  assign bit_miss = dut_out ^ exp_reg[idx_reg];

  // One-hot decode of the current vector index selects which truth-table bit is written.
  for (genvar gi = 0; gi < TT_W; gi++) begin : g_idx_sel
    assign idx_sel[gi] = (idx_reg == N_IN'(gi));
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    exp_next   = exp_reg;
    tt_next    = tt_reg;
    valid_next = valid_reg;
    mcnt_next  = mcnt_reg;
    ffi_next   = ffi_reg;
    ffv_next   = ffv_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETTLE;
          idx_next   = '0;
          exp_next   = expected_tt;
          tt_next    = '0;
          valid_next = 1'b0;
          mcnt_next  = '0;
          ffi_next   = '0;
          ffv_next   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        tt_next = (tt_reg & ~idx_sel) | (idx_sel & {TT_W{dut_out}});
        if (bit_miss) begin
          mcnt_next = mcnt_reg + 1'b1;
          if (!ffv_reg) begin
            ffi_next = idx_reg;
            ffv_next = 1'b1;
          end
        end
        if (last_idx) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_DONE: begin
        valid_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort drops the sweep without sampling in the current cycle or publishing results.
    if (kill) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      tt_next    = tt_reg;
      valid_next = valid_reg;
      mcnt_next  = mcnt_reg;
      ffi_next   = ffi_reg;
      ffv_next   = ffv_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      exp_reg   <= '0;
      tt_reg    <= '0;
      valid_reg <= 1'b0;
      mcnt_reg  <= '0;
      ffi_reg   <= '0;
      ffv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      exp_reg   <= exp_next;
      tt_reg    <= tt_next;
      valid_reg <= valid_next;
      mcnt_reg  <= mcnt_next;
      ffi_reg   <= ffi_next;
      ffv_reg   <= ffv_next;
    end
  end

  assign timer_load = (state_next == ST_SETTLE) && (state_reg != ST_SETTLE);
  assign timer_en   = (state_reg == ST_SETTLE);

  tt_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .en  (timer_en),
    .zero(timer_zero)
  );

  assign dut_in           = ((state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE)) ? idx_reg : '0;
  assign busy             = !in_idle;
  assign done             = (state_reg == ST_DONE) && !abort;
  assign result_valid     = valid_reg;
  assign tt_out           = tt_reg;
  assign match            = valid_reg && (tt_reg == exp_reg);
  assign mismatch_cnt     = mcnt_reg;
  assign first_fail_idx   = ffi_reg;
  assign first_fail_valid = ffv_reg;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench: a behavioural gate model drives dut_out and a reference model derives
// every expected truth table, mismatch count and first-fail index from the gate and golden tables.
module tb_tt_sweep_ctrl;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int TT_W   = 16;
  localparam int DONE_CYC = TT_W * (SETTLE + 1) + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic [TT_W-1:0] expected_tt;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            result_valid;
  logic [TT_W-1:0] tt_out;
  logic            match;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Gate model: output is the table entry, but garbage during the first cycle of a new vector.
  logic [TT_W-1:0] gate_tt;
  logic [N_IN-1:0] prev_in;

  always_ff @(posedge clk) prev_in <= dut_in;
  assign dut_out = gate_tt[dut_in] ^ (dut_in != prev_in);

  tt_sweep_ctrl #(
    .N_IN      (N_IN),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .expected_tt     (expected_tt),
    .dut_in          (dut_in),
    .dut_out         (dut_out),
    .busy            (busy),
    .done            (done),
    .result_valid    (result_valid),
    .tt_out          (tt_out),
    .match           (match),
    .mismatch_cnt    (mismatch_cnt),
    .first_fail_idx  (first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 0);
    check_eq({pfx, "_done"}, 32'(done), 0);
    check_eq({pfx, "_result_valid"}, 32'(result_valid), 0);
    check_eq({pfx, "_tt_out"}, 32'(tt_out), 0);
    check_eq({pfx, "_match"}, 32'(match), 0);
    check_eq({pfx, "_mismatch_cnt"}, 32'(mismatch_cnt), 0);
    check_eq({pfx, "_first_fail_idx"}, 32'(first_fail_idx), 0);
    check_eq({pfx, "_first_fail_valid"}, 32'(first_fail_valid), 0);
    check_eq({pfx, "_dut_in"}, 32'(dut_in), 0);
  endtask

  // Reference model: compare the gate's truth table against the golden table bit by bit.
  task automatic check_results(input logic [TT_W-1:0] gate, input logic [TT_W-1:0] exp);
    int cnt = 0;
    int ff  = -1;
    for (int i = 0; i < TT_W; i++) begin
      if (gate[i] != exp[i]) begin
        cnt++;
        if (ff < 0) ff = i;
      end
    end
    check_eq("result_valid", 32'(result_valid), 1);
    check_eq("tt_out", 32'(tt_out), 32'(gate));
    check_eq("match", 32'(match), (gate == exp) ? 1 : 0);
    check_eq("mismatch_cnt", 32'(mismatch_cnt), 32'(cnt));
    check_eq("first_fail_valid", 32'(first_fail_valid), (ff >= 0) ? 1 : 0);
    check_eq("first_fail_idx", 32'(first_fail_idx), (ff >= 0) ? 32'(ff) : 0);
  endtask

  // Called at the falling edge of sweep cycle 1; returns at the falling edge after done.
  task automatic monitor_sweep(input logic [TT_W-1:0] exp, input bit pulse_mid);
    int n = 1;
    int seq_err = 0;
    bit got_done = 1'b0;
    while (n <= 200) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy !== 1'b1) seq_err++;
      if (int'(dut_in) != (n - 1) / (SETTLE + 1)) seq_err++;
      if (pulse_mid && n == 10) start = 1'b1;
      if (pulse_mid && n == 11) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(got_done), 1);
    check_eq("done_cycle", 32'(n), 32'(DONE_CYC));
    check_eq("vector_seq", 32'(seq_err), 0);
    @(negedge clk);
    check_eq("done_pulse_width", 32'(done), 0);
    check_eq("busy_after_done", 32'(busy), 0);
    check_results(gate_tt, exp);
    $display("sweep gate=%04h exp=%04h done_cycle=%0d tt_out=%04h match=%0b cnt=%0d ff=%0d/%0b",
             gate_tt, exp, n, tt_out, match, mismatch_cnt, first_fail_idx, first_fail_valid);
  endtask

  task automatic sweep(input logic [TT_W-1:0] exp, input bit pulse_mid);
    expected_tt = exp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expected_tt = ~exp;  // the latched copy must be what gets compared
    monitor_sweep(exp, pulse_mid);
  endtask

  initial begin
    int d_cnt;
    int v_cnt;
    logic [TT_W-1:0] g;
    logic [TT_W-1:0] e;

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    expected_tt = '0;
    gate_tt = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Matching table, with an ignored start pulse in the middle of the sweep
    gate_tt = 16'h3A17;
    sweep(16'h3A17, 1'b1);
    // Single-bit mismatch at index 0
    sweep(16'h3A16, 1'b0);
    // Stuck-at-0 netlist
    gate_tt = 16'h0000;
    sweep(16'h3A17, 1'b0);

    // Start held high: second sweep begins right after the IDLE cycle following done
    gate_tt = 16'h3A17;
    expected_tt = 16'h3A17;
    start = 1'b1;
    @(negedge clk);
    monitor_sweep(16'h3A17, 1'b0);
    @(negedge clk);
    check_eq("restart_busy", 32'(busy), 1);
    check_eq("restart_result_valid", 32'(result_valid), 0);
    check_eq("restart_tt_out", 32'(tt_out), 0);
    check_eq("restart_mismatch_cnt", 32'(mismatch_cnt), 0);
    start = 1'b0;
    monitor_sweep(16'h3A17, 1'b0);

    // Abort at cycle 20
    expected_tt = 16'h3A17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_dut_in", 32'(dut_in), 0);
    d_cnt = 0;
    v_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) d_cnt++;
      if (result_valid) v_cnt++;
    end
    check_eq("abort_no_done", 32'(d_cnt), 0);
    check_eq("abort_no_valid", 32'(v_cnt), 0);
    $display("abort at cycle 20: busy=%0b dut_in=%0d", busy, dut_in);
    sweep(16'h3A17, 1'b0);

    // start+abort together in IDLE: start ignored, held results untouched
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 0);
    check_eq("idle_abort_result_valid", 32'(result_valid), 1);
    check_eq("idle_abort_tt_out", 32'(tt_out), 32'(16'h3A17));
    $display("start+abort in idle: busy=%0b result_valid=%0b", busy, result_valid);

    // Asynchronous reset mid-SETTLE after a mismatch has been recorded
    expected_tt = 16'h3A16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("async reset mid-settle: busy=%0b mismatch_cnt=%0d", busy, mismatch_cnt);
    sweep(16'h3A17, 1'b0);

    // Randomized netlists and golden tables
    for (int k = 0; k < 6; k++) begin
      g = 16'($urandom);
      e = (k % 2 == 0) ? g : (g ^ 16'($urandom));
      gate_tt = g;
      sweep(e, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
